// File: rtl/rrr_pkg.sv
// Shared encodings for the sequential right shifter/rotator.
// Op codes and FSM states; 2'b11 is decoded as rotate by the stage logic.
// Helper constants only, no logic.
package rrr_pkg;

    localparam logic [1:0] OP_ROR = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/rrr_stage.sv
// One combinational log-stage of the right shifter: shift/rotate by a one-hot amount.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module rrr_stage
    import rrr_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       op,
    input  logic             en,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] upper;

    // The one-hot amount (bit k set) is numerically 2**k, so it is the shift distance.
    // Bits entering from the top come from 'upper': zeros, sign copies, or the word itself.
    always_comb begin
        case (op)
            OP_SRL:  upper = '0;
            OP_SRA:  upper = {WIDTH{in[WIDTH-1]}};
            default: upper = in;
        endcase
        out = en ? WIDTH'({upper, in} >> amount) : in;
    end

endmodule

// File: rtl/rrr_seq.sv
// Sequential ROR/SRL/SRA unit, one log-stage per clock; ROTR_EARLY_DONE_EN enables early finish.
// Latency: CNT_W edges accept->out_valid (early mode: index of highest set cnt bit + 1, min 1).
// Backpressure: single request in flight; in_ready only in IDLE, result held in DONE until out_ready.
module rrr_seq
    import rrr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in,
    input  logic [$clog2(WIDTH)-1:0]   cnt,
    input  logic [1:0]                 op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int STG_W = $clog2(CNT_W);

    state_t           state_q, state_d;
    logic [STG_W-1:0] stage_q, stage_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] stage_out;
    logic [CNT_W-1:0] stage_amt;
    logic             last_stage;
    logic             finish;

    assign stage_amt = CNT_W'(1) << stage_q;

    rrr_stage #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_stage (
        .in     (acc_q),
        .op     (op_q),
        .en     (cnt_q[stage_q]),
        .amount (stage_amt),
        .out    (stage_out)
    );

    assign last_stage = (stage_q == STG_W'(CNT_W - 1));

`ifdef ROTR_EARLY_DONE_EN
    // Stop once no higher cnt bit remains to be applied.
    assign finish = last_stage || (((cnt_q >> stage_q) >> 1) == '0);
`else
    assign finish = last_stage;
`endif

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    acc_d      = in;
                    cnt_d      = cnt;
                    op_d       = op;
                    stage_d    = '0;
                    in_ready_d = 1'b0;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_d = stage_out;
                if (finish) begin
                    stage_d     = '0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    stage_d = stage_q + STG_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            stage_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            op_q        <= OP_ROR;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = acc_q;

endmodule

// File: tb/tb_rrr_seq.sv
// Bench for rrr_seq: directed vector table, DONE-hold and mid-shift reset sequences, random traffic.
module tb_rrr_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] din;
    logic [3:0]  cnt;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dout;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] sb[$];

    typedef struct {
        logic [1:0]  op;
        logic [15:0] din;
        logic [3:0]  cnt;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[6];

    rrr_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .cnt       (cnt),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] ref_model(input logic [1:0] o, input logic [15:0] v, input int n);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < n; i++) begin
            case (o)
                2'b01:   r = {1'b0, r[15:1]};
                2'b10:   r = {r[15], r[15:1]};
                default: r = {r[0], r[15:1]};
            endcase
        end
        return r;
    endfunction

    function automatic int exp_lat(input logic [3:0] c);
        int h;
        h = 4;
`ifdef ROTR_EARLY_DONE_EN
        h = 1;
        for (int i = 0; i < 4; i++) if (c[i]) h = i + 1;
`endif
        return h;
    endfunction

    // Issue one request, check latency, hold the result for 'stall' cycles, then consume it.
    task automatic do_req(input string name, input logic [1:0] o, input logic [15:0] v,
                          input logic [3:0] c, input logic [15:0] exp, input int stall);
        int lat;
        logic [15:0] got;
        logic [15:0] want;
        chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        din      = v;
        cnt      = c;
        op       = o;
        sb.push_back(exp);
        tick();
        in_valid = 1'b0;
        din      = $urandom;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 20);
        chk({name, "_latency"}, lat, exp_lat(c));
        got = dout;
        for (int s = 0; s < stall; s++) begin
            if (dout !== got || !out_valid) begin
                chk({name, "_stall_hold"}, {15'd0, out_valid, dout}, {15'd0, 1'b1, got});
            end
            tick();
        end
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            want = sb.pop_front();
            chk({name, "_result"}, {16'd0, dout}, {16'd0, want});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        tbl[0] = '{op: 2'b00, din: 16'h8001, cnt: 4'd1,  exp: 16'hC000};
        tbl[1] = '{op: 2'b01, din: 16'h8001, cnt: 4'd4,  exp: 16'h0800};
        tbl[2] = '{op: 2'b10, din: 16'h8000, cnt: 4'd15, exp: 16'hFFFF};
        tbl[3] = '{op: 2'b10, din: 16'h7FF0, cnt: 4'd4,  exp: 16'h07FF};
        tbl[4] = '{op: 2'b00, din: 16'h1234, cnt: 4'd0,  exp: 16'h1234};
        tbl[5] = '{op: 2'b11, din: 16'h0001, cnt: 4'd8,  exp: 16'h0100};

        rst = 1'b1; in_valid = 1'b0; din = '0; cnt = '0; op = '0; out_ready = 1'b0;
        tick();
        tick();
        chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out",       {16'd0, dout},      32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            do_req($sformatf("vec%0d", i), tbl[i].op, tbl[i].din, tbl[i].cnt, tbl[i].exp, 0);
        end

        // Hold DONE for 5 cycles with stray in_valid pulses that must be ignored.
        in_valid = 1'b1; din = 16'hF00F; cnt = 4'd4; op = 2'b00;
        sb.push_back(16'hFF00);
        tick();
        din = 16'hAAAA; cnt = 4'd1;
        for (int i = 0; i < 8 && !out_valid; i++) tick();
        chk("hold_valid_rise", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2) == 0;
            chk($sformatf("hold_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("hold_out_%0d", i), {16'd0, dout}, 32'hFF00);
            chk($sformatf("hold_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        void'(sb.pop_front());
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold_release_valid", {31'd0, out_valid}, 32'd0);
        chk("hold_release_ready", {31'd0, in_ready},  32'd1);
        tick(); tick(); tick(); tick(); tick();
        chk("hold_no_queued_req", {31'd0, out_valid}, 32'd0);

        // Reset during the SHIFT phase at stage 2 discards the request.
        in_valid = 1'b1; din = 16'h1357; cnt = 4'd15; op = 2'b01;
        sb.push_back(16'h0000);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("midrst_out",       {16'd0, dout},      32'd0);
        do_req("post_rst", 2'b10, 16'h9000, 4'd3, 16'hF200, 1);

        for (int i = 0; i < 1000; i++) begin
            logic [1:0]  ro;
            logic [15:0] rv;
            logic [3:0]  rc;
            ro = 2'($urandom_range(0, 3));
            rv = 16'($urandom);
            rc = 4'($urandom_range(0, 15));
            do_req($sformatf("rnd%0d", i), ro, rv, rc, ref_model(ro, rv, int'(rc)),
                   int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
